count_seq_checker: RTL
======================

Name: count_seq_checker

Overview:
Receiving end of the free-running counter stream: consumes sampled counter values and checks that each valid sample equals the previous one plus 1, modulo 2^WIDTH. Acquires lock after a run of consecutive good samples and flags every sequence break. Keeps a saturating error tally. Sits beside any counter-driven output as an on-chip self-check, replacing bench-only checking.

Parameters:
WIDTH, 31, width of the counter data being checked
LOCK_COUNT, 4, consecutive matching samples (including the first) needed to assert lock; legal range 1..255
LOSS_COUNT, 3, consecutive mismatches in LOCKED that drop lock; legal range 1..255
ERR_CNT_W, 16, width of the saturating error counter

Ports:
CLK  in  1  system clock, rising-edge
RST  in  1  synchronous reset, active-high
data_in  in  WIDTH  sampled counter value
valid_in  in  1  data_in is a new sample this cycle
clr_err  in  1  clears err_count
locked  out  1  sequence lock achieved
error_pulse  out  1  one-cycle strobe per counted mismatch
expected  out  WIDTH  next value the checker expects
err_count  out  ERR_CNT_W  saturating count of mismatches while LOCKED

Behaviour:
- Single clock domain (CLK). Reset is synchronous, active-high (RST); no asynchronous paths.
- While RST=1 at a CLK edge: state=IDLE, locked=0, error_pulse=0, expected=0, err_count=0, run=0, miss=0. RST overrides all other inputs.
- All outputs are registered and reflect a sample 1 cycle after it is presented.
- Cycles with valid_in=0: state, expected, run and miss hold; error_pulse=0.
- State IDLE, on a valid sample: expected<=data_in+1, run<=1. Go to LOCKED if LOCK_COUNT==1, else go to ACQUIRE.
- State ACQUIRE, on a valid sample:
  - Match (data_in==expected): expected<=data_in+1, run<=run+1. When run+1==LOCK_COUNT, go to LOCKED, locked<=1, miss<=0.
  - Mismatch: restart the run with expected<=data_in+1, run<=1. No error_pulse and no err_count increment.
- State LOCKED, on a valid sample:
  - Match: expected<=data_in+1, miss<=0.
  - Mismatch: error_pulse<=1, err_count increments (saturating), expected<=data_in+1 (re-align, so a single skip causes exactly one error), miss<=miss+1.
  - When miss+1==LOSS_COUNT: locked<=0, go to ACQUIRE with run<=1, miss<=0.
- Arithmetic: all +1 is modulo 2^WIDTH. An all-ones sample followed by 0 is a match. The comparison uses the full WIDTH bits.
- err_count saturates at 2^ERR_CNT_W-1 and holds there.
- clr_err=1: err_count<=0. If clr_err and a counted mismatch coincide, err_count<=1; error_pulse still fires.
- locked is 1 exactly while state==LOCKED.

Decomposition:
- Shared package `count_seq_pkg`: state enum {IDLE, ACQUIRE, LOCKED} as a 2-bit encoding, and the run/miss counter width constant (8 bits).
- One natural sub-module, `sat_counter`: a saturating up-counter with clear and increment inputs and a width parameter. It implements err_count.

Test Plan (bench parameters: WIDTH=31, LOCK_COUNT=4, LOSS_COUNT=3, ERR_CNT_W=16 unless stated; valid_in=1 every cycle unless stated):
1. Hold RST=1 for 2 cycles with garbage data_in -> locked=0, error_pulse=0, err_count=0, expected=0.
2. After reset, feed 0,1,2,...,9 -> locked rises the cycle after sample 3; expected=10 after sample 9; err_count=0; no error_pulse.
3. While locked, feed 10,11,13,14 -> a single error_pulse after 13; err_count=1; locked stays 1; expected=15.
4. Feed 2147483646, 2147483647, 0, 1 while locked -> no error_pulse; expected=2.
5. While locked, feed 100, 500, 7 -> 3 error_pulses; err_count increases by 3; locked falls after 7. Then 8,9,10 -> locked re-asserts after 10.
6. Toggle valid_in low for 5 cycles mid-stream with a changing data_in -> no change in state. Then assert clr_err together with a mismatch -> err_count=1. Rerun with ERR_CNT_W=2 and 5 locked mismatches (LOSS_COUNT=8) -> err_count holds at 3.

Source files
------------

// File: rtl/count_seq_pkg.sv
// Shared types and constants for the counter-sequence checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package count_seq_pkg;

  // Width of the run / miss counters; LOCK_COUNT and LOSS_COUNT top out at 255.
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

endpackage

// File: rtl/count_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear+inc together loads 1.
// Latency: 1 cycle from clr/inc to cnt.
// Backpressure: none; sticks at all-ones until cleared.
// Ports: clk, rst (sync, active-high), clr, inc, cnt[W-1:0].
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      // A coinciding event still counts, so the tally restarts at 1.
      cnt_d = inc ? W'(1) : '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/count_seq_checker.sv
// Checks a sampled counter stream increments by 1 (mod 2^WIDTH); locks after
// LOCK_COUNT good samples, drops after LOSS_COUNT consecutive misses in lock.
// Latency: 1 cycle, all outputs registered. Backpressure: none, valid_in only.
// Ports: CLK, RST (sync, active-high), data_in/valid_in sample input, clr_err
// clears the tally; locked, error_pulse, expected, err_count status outputs.
module count_seq_checker
  import count_seq_pkg::*;
#(
  parameter int WIDTH      = 31,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 valid_in,
  input  logic                 clr_err,
  output logic                 locked,
  output logic                 error_pulse,
  output logic [WIDTH-1:0]     expected,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] LOCK_C = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] LOSS_C = CNT_W'(LOSS_COUNT);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   expected_q, expected_d;
  logic [CNT_W-1:0]   run_q, run_d;
  logic [CNT_W-1:0]   miss_q, miss_d;
  logic               error_pulse_q, error_pulse_d;

  logic [WIDTH-1:0]   data_inc;
  logic [CNT_W-1:0]   run_inc;
  logic [CNT_W-1:0]   miss_inc;
  logic               match;
  logic               err_inc;

  // Wraps naturally: all-ones + 1 = 0, so all-ones followed by 0 matches.
  assign data_inc = data_in + WIDTH'(1);
  assign run_inc  = run_q + ONE_C;
  assign miss_inc = miss_q + ONE_C;
  assign match    = (data_in == expected_q);

  always_comb begin
    state_d       = state_q;
    expected_d    = expected_q;
    run_d         = run_q;
    miss_d        = miss_q;
    error_pulse_d = 1'b0;
    err_inc       = 1'b0;

    if (valid_in) begin
      // Every valid sample re-aligns the expectation, so one skip costs one error.
      expected_d = data_inc;
      case (state_q)
        IDLE: begin
          run_d   = ONE_C;
          miss_d  = '0;
          state_d = (LOCK_C == ONE_C) ? LOCKED : ACQUIRE;
        end
        ACQUIRE: begin
          if (match) begin
            run_d = run_inc;
            if (run_inc == LOCK_C) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else begin
            // Restarted run is one sample long; enough on its own if LOCK_COUNT is 1.
            run_d = ONE_C;
            if (LOCK_C == ONE_C) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end
        end
        LOCKED: begin
          if (match) begin
            miss_d = '0;
          end else begin
            error_pulse_d = 1'b1;
            err_inc       = 1'b1;
            miss_d        = miss_inc;
            if (miss_inc == LOSS_C) begin
              state_d = ACQUIRE;
              run_d   = ONE_C;
              miss_d  = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      expected_q    <= '0;
      run_q         <= '0;
      miss_q        <= '0;
      error_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      expected_q    <= expected_d;
      run_q         <= run_d;
      miss_q        <= miss_d;
      error_pulse_q <= error_pulse_d;
    end
  end

  sat_counter #(
    .W (ERR_CNT_W)
  ) u_err_cnt (
    .clk (CLK),
    .rst (RST),
    .clr (clr_err),
    .inc (err_inc),
    .cnt (err_count)
  );

  assign locked      = (state_q == LOCKED);
  assign error_pulse = error_pulse_q;
  assign expected    = expected_q;

endmodule
